trdb_branch_map: RTL and testbench
==================================

Name: trdb_branch_map

Overview:
- Upstream neighbour of the packet emitter.
- Accumulates the taken/not-taken outcome of every retired conditional branch into a branch map and keeps a running branch count.
- Provides the branch_map and branch-count fields used for format 0/1 packets, and flags when the map is full so the emitter must drain it.
- The emitter clears the map with a flush once it has sampled the contents.

Parameters:
- BMAP_LEN, 31, maximum branches held in the map (E-Trace limit).
- CNT_LEN, 5, width of the branch counter; must satisfy 2**CNT_LEN > BMAP_LEN.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  an instruction retires this cycle; all other per-instruction inputs are qualified by it.
- is_branch_i  in  1  retiring instruction is a conditional branch.
- is_branch_taken_i  in  1  branch outcome, 1 = taken.
- flush_i  in  1  emitter has consumed the current map; clear it.
- branch_map_o  out  BMAP_LEN  accumulated outcomes, bit i = i-th branch since last flush; bit value 1 = NOT taken, 0 = taken (E-Trace encoding); bits at index >= branch_cnt_o are 0.
- branch_cnt_o  out  CNT_LEN  number of valid bits in branch_map_o (0..BMAP_LEN).
- is_full_o  out  1  branch_cnt_o == BMAP_LEN.
- is_empty_o  out  1  branch_cnt_o == 0.
- overflow_o  out  1  one-cycle pulse: a branch was dropped because the map was full and not flushed.

Behaviour:
- Reset (rst_ni low, asynchronous): branch_map_o = 0, branch_cnt_o = 0, is_full_o = 0, is_empty_o = 1, overflow_o = 0. Reset mid-accumulation discards the contents immediately.
- All outputs are registered and sampled on the rising edge of clk_i. A branch accepted in cycle N is visible in outputs from cycle N+1.
- branch event = valid_i & is_branch_i. valid_i with is_branch_i = 0 leaves state unchanged. is_branch_taken_i is ignored unless a branch event occurs.
- Write bit = ~is_branch_taken_i.
- No event, no flush: hold state; overflow_o = 0.
- Event, no flush, cnt < BMAP_LEN:
  - branch_map[cnt] <= write bit;
  - cnt <= cnt + 1.
- Event, no flush, cnt == BMAP_LEN:
  - map and count unchanged;
  - overflow_o = 1 for one cycle;
  - is_full_o stays 1.
- Flush, no event: map <= 0, cnt <= 0.
- Flush and event in the same cycle:
  - flush applies to the old contents, which the emitter samples combinationally from the outputs this cycle;
  - new branch lands at bit 0: map <= {0..., write bit}, cnt <= 1;
  - no overflow, even when the map was full.
- Flush while empty: no effect, legal.
- is_full_o and is_empty_o are derived from the next-state count and registered with it. They never disagree with branch_cnt_o in the same cycle.
- Counter never wraps: saturates at BMAP_LEN, and only a flush or reset lowers it.
- The emitter is required to flush in the first cycle is_full_o is high. The block tolerates late flush by dropping branches with overflow_o.

Test Plan:
- Reset then idle, valid_i = 0 for 10 cycles -> map = 0, cnt = 0, is_empty_o = 1, is_full_o = 0, overflow_o = 0 throughout.
- Three branches: taken, not-taken, not-taken on consecutive cycles -> one cycle after the last, map = 0b110, cnt = 3, is_empty_o = 0. A non-branch valid_i in between does not change the map.
- 31 not-taken branches -> map = 0x7FFFFFFF, cnt = 31, is_full_o = 1. A 32nd branch without flush -> overflow_o pulses 1 for exactly one cycle, map/cnt unchanged.
- Map full, flush_i together with a taken branch -> next cycle map = 0, cnt = 1, is_full_o = 0, overflow_o = 0. Same with a not-taken branch -> map = 0b1, cnt = 1.
- 5 branches, then flush_i alone -> next cycle map = 0, cnt = 0, is_empty_o = 1. A second flush while empty -> no change.
- Assert rst_ni low asynchronously between clock edges with cnt = 12 -> outputs return to reset values before the next edge. After release, the first branch lands at bit 0.

Source files
------------

// File: rtl/trdb_branch_map.sv
// rtl/trdb_branch_map.sv - branch outcome map and branch counter feeding the trace packet emitter
//
// Accumulates the outcome of every retired conditional branch into a
// bit map (1 = not taken, 0 = taken) and keeps a saturating count of
// the valid bits. The emitter samples the outputs and clears them with
// flush_i.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   valid_i            an instruction retires this cycle
//   is_branch_i        retiring instruction is a conditional branch
//   is_branch_taken_i  branch outcome, 1 = taken
//   flush_i            emitter consumed the current map; clear it
//   branch_map_o       accumulated outcomes, bit i = i-th branch since flush
//   branch_cnt_o       number of valid bits in branch_map_o
//   is_full_o          branch_cnt_o == BMAP_LEN
//   is_empty_o         branch_cnt_o == 0
//   overflow_o         one-cycle pulse: branch dropped because map was full
module trdb_branch_map #(
  parameter int BMAP_LEN = 31,
  parameter int CNT_LEN  = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                is_branch_i,
  input  logic                is_branch_taken_i,
  input  logic                flush_i,
  output logic [BMAP_LEN-1:0] branch_map_o,
  output logic [CNT_LEN-1:0]  branch_cnt_o,
  output logic                is_full_o,
  output logic                is_empty_o,
  output logic                overflow_o
);

  localparam logic [CNT_LEN-1:0] MAX_CNT = CNT_LEN'(BMAP_LEN);

  logic                branch_event;
  logic                write_bit;
  logic [BMAP_LEN-1:0] write_vec;
  logic [BMAP_LEN-1:0] map_d;
  logic [CNT_LEN-1:0]  cnt_d;
  logic                overflow_d;

  assign branch_event = valid_i & is_branch_i;
  assign write_bit    = ~is_branch_taken_i;
  assign write_vec    = {{(BMAP_LEN-1){1'b0}}, write_bit};

  always_comb begin
    map_d      = branch_map_o;
    cnt_d      = branch_cnt_o;
    overflow_d = 1'b0;
    if (flush_i) begin
      // The emitter has already sampled the old contents this cycle, so a
      // coincident branch starts the new map at bit 0 and never overflows.
      if (branch_event) begin
        map_d = write_vec;
        cnt_d = CNT_LEN'(1);
      end else begin
        map_d = '0;
        cnt_d = '0;
      end
    end else if (branch_event) begin
      if (branch_cnt_o < MAX_CNT) begin
        // Bits at and above the count are always zero, so OR-ing in the
        // shifted bit is equivalent to writing map[cnt].
        map_d = branch_map_o | (write_vec << branch_cnt_o);
        cnt_d = branch_cnt_o + CNT_LEN'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_map_o <= '0;
      branch_cnt_o <= '0;
      is_full_o    <= 1'b0;
      is_empty_o   <= 1'b1;
      overflow_o   <= 1'b0;
    end else begin
      branch_map_o <= map_d;
      branch_cnt_o <= cnt_d;
      // Flags are decoded from the next count so they always agree with it.
      is_full_o    <= (cnt_d == MAX_CNT);
      is_empty_o   <= (cnt_d == '0);
      overflow_o   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_trdb_branch_map.sv
// tb/tb_trdb_branch_map.sv - self-checking scoreboard bench for trdb_branch_map
module tb_trdb_branch_map;

  typedef struct packed {
    logic [30:0] map;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;
  } snap_t;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        is_branch;
  logic        taken;
  logic        flush;
  logic [30:0] branch_map;
  logic [4:0]  branch_cnt;
  logic        is_full;
  logic        is_empty;
  logic        overflow;

  int n_tests;
  int n_fail;

  // reference model state
  logic [30:0] m_map;
  int          m_cnt;
  logic        m_ovf;

  snap_t sb[$];
  snap_t got;
  snap_t exp_s;

  trdb_branch_map #(.BMAP_LEN(31), .CNT_LEN(5)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .valid_i           (valid),
    .is_branch_i       (is_branch),
    .is_branch_taken_i (taken),
    .flush_i           (flush),
    .branch_map_o      (branch_map),
    .branch_cnt_o      (branch_cnt),
    .is_full_o         (is_full),
    .is_empty_o        (is_empty),
    .overflow_o        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t observe();
    snap_t s;
    s.map   = branch_map;
    s.cnt   = branch_cnt;
    s.full  = is_full;
    s.empty = is_empty;
    s.ovf   = overflow;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.map   = m_map;
    s.cnt   = 5'(m_cnt);
    s.full  = (m_cnt == 31);
    s.empty = (m_cnt == 0);
    s.ovf   = m_ovf;
    return s;
  endfunction

  task automatic model_reset();
    m_map = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drives one cycle of stimulus, advances the model and pushes the
  // expected post-edge output state; returns #1 after the edge.
  task automatic drive(input logic v, input logic b, input logic t, input logic f);
    logic ev;
    valid = v; is_branch = b; taken = t; flush = f;
    ev = v & b;
    m_ovf = 1'b0;
    if (f) begin
      m_map = '0;
      m_cnt = 0;
      if (ev) begin
        m_map[0] = ~t;
        m_cnt    = 1;
      end
    end else if (ev) begin
      if (m_cnt < 31) begin
        m_map[m_cnt] = ~t;
        m_cnt        = m_cnt + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    sb.push_back(model_snap());
    @(posedge clk);
    #1;
    valid = 1'b0; is_branch = 1'b0; taken = 1'b0; flush = 1'b0;
  endtask

  task automatic pop_exp(output snap_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    valid = 1'b0; is_branch = 1'b0; taken = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got = observe();
    n_tests++;
    if (got !== {31'h0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", got, {31'h0, 5'd0, 1'b0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      pop_exp(exp_s, ok);
      got = observe();
      n_tests++;
      if (!ok || got !== exp_s) begin
        n_fail++;
        $display("FAIL idle_cycle_%0d got=%h exp=%h", i, got, exp_s);
      end
    end
  endtask

  task automatic test_three_branches();
    bit ok;
    // taken, non-branch retire, not-taken, not-taken
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop_exp(exp_s, ok);
      if (i == 3) begin
        got = observe();
        n_tests++;
        if (!ok || got !== exp_s) begin
          n_fail++;
          $display("FAIL three_branches got=%h exp=%h", got, exp_s);
        end
      end
    end
    n_tests++;
    if (branch_map !== 31'b110 || branch_cnt !== 5'd3 || is_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL three_branches_const map=%h cnt=%0d empty=%b exp map=6 cnt=3 empty=0",
               branch_map, branch_cnt, is_empty);
    end
  endtask

  task automatic fill_not_taken(input string name);
    bit ok;
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      pop_exp(exp_s, ok);
      got = observe();
      n_tests++;
      if (!ok || got !== exp_s) begin
        n_fail++;
        $display("FAIL %s_fill_%0d got=%h exp=%h", name, i, got, exp_s);
      end
    end
  endtask

  task automatic test_full_overflow();
    bit ok;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    pop_exp(exp_s, ok);
    fill_not_taken("full");
    n_tests++;
    if (branch_map !== 31'h7FFFFFFF || branch_cnt !== 5'd31 || is_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_const map=%h cnt=%0d full=%b exp map=7fffffff cnt=31 full=1",
               branch_map, branch_cnt, is_full);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    pop_exp(exp_s, ok);
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse got=%h exp=%h", got, exp_s);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    pop_exp(exp_s, ok);
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_one_cycle got=%h exp=%h", got, exp_s);
    end
  endtask

  task automatic test_flush_with_branch();
    bit ok;
    // map is full from the previous test: flush + taken
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    pop_exp(exp_s, ok);
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || got !== {31'h0, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_taken got=%h exp=%h", got, exp_s);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    pop_exp(exp_s, ok);
    fill_not_taken("refill");
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    pop_exp(exp_s, ok);
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || got !== {31'h1, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_not_taken got=%h exp=%h", got, exp_s);
    end
  endtask

  task automatic test_flush_alone();
    bit ok;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    pop_exp(exp_s, ok);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'(i % 2), 1'b0);
      pop_exp(exp_s, ok);
    end
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s) begin
      n_fail++;
      $display("FAIL five_branches got=%h exp=%h", got, exp_s);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      pop_exp(exp_s, ok);
      got = observe();
      n_tests++;
      if (!ok || got !== exp_s || got !== {31'h0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL flush_alone_%0d got=%h exp=%h", i, got, exp_s);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      pop_exp(exp_s, ok);
    end
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || branch_cnt !== 5'd12) begin
      n_fail++;
      $display("FAIL pre_reset_cnt12 got=%h exp=%h", got, exp_s);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = observe();
    n_tests++;
    if (got !== model_snap()) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", got, model_snap());
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    pop_exp(exp_s, ok);
    got = observe();
    n_tests++;
    if (!ok || got !== exp_s || got !== {31'h1, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_bit0 got=%h exp=%h", got, exp_s);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_three_branches();
    test_full_overflow();
    test_flush_with_branch();
    test_flush_alone();
    test_async_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
